mem_port_arbiter: RTL and testbench

- Shares the single-port instruction/data RAM between the instruction-fetch port and the data port (LDR/STR) of the RISC CPU.
- Sits between the controller/datapath and the RAM.
- Serializes requests, arbitrates round-robin on ties, sequences the RAM read latency, and returns a one-cycle ack with read data to the requester.

---
 rtl/mem_port_arbiter.sv | 69 ++++++
 tb/tb_mem_port_arbiter.sv | 135 +++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin fetch/data arbiter for a single-port RAM (fetch/data request ports in, RAM port out, busy/grant_d status)
module mem_port_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wr_en,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              grant_d
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state, state_nx;
  logic owner_d, last_d, we_q, req, pick_d, rd_done;
  logic [2:0] cnt;
  assign req = if_req | d_req;
  assign pick_d = d_req & (~if_req | ~last_d);
  assign rd_done = ~we_q & (cnt == 3'(RD_LAT));
  assign busy = state != IDLE;
  assign grant_d = busy & owner_d;
  assign mem_wr_en = (state == ACCESS) & we_q;
  assign if_ack = (state == RESP) & ~owner_d;
  assign d_ack = (state == RESP) & owner_d;
  always_ff @(posedge clk) state <= rst ? IDLE : state_nx;
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE   ? (req ? ACCESS : IDLE) :
               state == ACCESS ? ((we_q | rd_done) ? RESP : ACCESS) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr <= '0;
      mem_wdata <= '0;
      if_rdata <= '0;
      d_rdata <= '0;
      owner_d <= 1'b0;
      last_d <= 1'b1;
      we_q <= 1'b0;
      cnt <= '0;
    end else begin
      if (state == IDLE && req) begin
        mem_addr <= pick_d ? d_addr : if_addr;
        mem_wdata <= pick_d ? d_wdata : mem_wdata;
        we_q <= pick_d & d_we;
        owner_d <= pick_d;
        last_d <= pick_d;
        cnt <= '0;
      end else if (state == ACCESS) cnt <= cnt + 3'd1;
      if (state == ACCESS && rd_done) begin
        if (owner_d) d_rdata <= mem_rdata;
        else if_rdata <= mem_rdata;
      end
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of mem_port_arbiter at RD_LAT=1 and RD_LAT=3
module tb_mem_port_arbiter;
  logic clk = 0, rst, if_req, d_req, d_req3, d_we;
  logic [7:0] if_addr, d_addr;
  logic [15:0] d_wdata;
  logic if_ack, d_ack, wr1, busy, grant_d;
  logic [15:0] if_rdata, d_rdata, wd1, rd1;
  logic [7:0] ma1;
  logic if_ack3, d_ack3, wr3, busy3, grant_d3;
  logic [15:0] if_rdata3, d_rdata3, wd3, rd3;
  logic [7:0] ma3;
  logic [15:0] ram1 [256];
  logic [15:0] ram3 [256];
  logic [15:0] p3 [3];
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  mem_port_arbiter #(.RD_LAT(1)) dut (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
    .if_rdata(if_rdata), .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .mem_addr(ma1), .mem_wdata(wd1), .mem_wr_en(wr1),
    .mem_rdata(rd1), .busy(busy), .grant_d(grant_d));
  mem_port_arbiter #(.RD_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .if_req(1'b0), .if_addr(if_addr), .if_ack(if_ack3),
    .if_rdata(if_rdata3), .d_req(d_req3), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack3), .d_rdata(d_rdata3), .mem_addr(ma3), .mem_wdata(wd3), .mem_wr_en(wr3),
    .mem_rdata(rd3), .busy(busy3), .grant_d(grant_d3));
  always @(posedge clk) begin
    if (rst) begin
      ram1[8'h10] <= 16'hBEEF;
      ram1[8'h05] <= 16'h00FF;
      ram3[8'h10] <= 16'hBEEF;
      ram3[8'h05] <= 16'h00FF;
    end
    if (wr1) ram1[ma1] <= wd1;
    if (wr3) ram3[ma3] <= wd3;
    rd1 <= ram1[ma1];
    p3[0] <= ram3[ma3];
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign rd3 = p3[2];
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  initial begin
    rst = 1; if_req = 0; d_req = 0; d_req3 = 0; d_we = 0;
    if_addr = 0; d_addr = 0; d_wdata = 0;
    tick; tick;
    rst = 0;
    chk("rst_busy", busy, 0); chk("rst_if_ack", if_ack, 0); chk("rst_d_ack", d_ack, 0);
    chk("rst_mem_addr", ma1, 0); chk("rst_wr_en", wr1, 0); chk("rst_grant_d", grant_d, 0);
    chk("rst_if_rdata", if_rdata, 0); chk("rst_d_rdata", d_rdata, 0);
    if_addr = 8'h10; if_req = 1;
    tick; chk("f_addr", ma1, 8'h10); chk("f_busy", busy, 1); chk("f_grant_d", grant_d, 0);
    tick; chk("f_ack_n2", if_ack, 0);
    tick; chk("f_ack_n3", if_ack, 1); chk("f_rdata", if_rdata, 16'hBEEF); chk("f_d_ack", d_ack, 0);
    if_req = 0;
    tick; chk("f_ack_n4", if_ack, 0); chk("f_idle", busy, 0); chk("f_rdata_hold", if_rdata, 16'hBEEF);
    d_we = 1; d_addr = 8'h20; d_wdata = 16'h1234; d_req = 1;
    tick; chk("w_wr_en", wr1, 1); chk("w_addr", ma1, 8'h20); chk("w_wdata", wd1, 16'h1234);
    chk("w_grant_d1", grant_d, 1); chk("w_ack_n1", d_ack, 0);
    tick; chk("w_ack_n2", d_ack, 1); chk("w_wr_en_n2", wr1, 0); chk("w_grant_d2", grant_d, 1);
    d_req = 0;
    tick; chk("w_ack_n3", d_ack, 0); chk("w_grant_d3", grant_d, 0);
    d_we = 0; d_req = 1;
    tick; tick;
    tick; chk("rb_ack", d_ack, 1); chk("rb_rdata", d_rdata, 16'h1234); chk("rb_if_rdata", if_rdata, 16'hBEEF);
    d_req = 0;
    tick;
    rst = 1; tick; rst = 0;
    if_addr = 8'h10; d_addr = 8'h20; d_we = 0; if_req = 1; d_req = 1;
    tick; chk("t_busy", busy, 1); chk("t_first_fetch", grant_d, 0);
    tick;
    tick; chk("t_if_ack", if_ack, 1); chk("t_d_ack_lo", d_ack, 0); chk("t_if_rdata", if_rdata, 16'hBEEF);
    tick; chk("t_gap", busy, 0);
    tick; chk("t_then_data", grant_d, 1);
    tick;
    tick; chk("t_d_ack", d_ack, 1); chk("t_if_ack_lo", if_ack, 0); chk("t_d_rdata", d_rdata, 16'h1234);
    d_req = 0;
    tick; chk("t_gap2", busy, 0);
    tick; chk("t_busy3", busy, 1); chk("t_fetch_again", grant_d, 0);
    tick;
    tick; chk("t_if_ack2", if_ack, 1);
    if_req = 0;
    tick;
    d_addr = 8'h05; d_we = 0; d_req3 = 1;
    tick; chk("l3_addr_n1", ma3, 8'h05);
    tick; tick;
    tick; chk("l3_addr_n4", ma3, 8'h05); chk("l3_ack_n4", d_ack3, 0);
    tick; chk("l3_ack_n5", d_ack3, 1); chk("l3_rdata", d_rdata3, 16'h00FF);
    d_req3 = 0;
    tick; chk("l3_ack_n6", d_ack3, 0);
    if_addr = 8'h10; if_req = 1;
    tick; chk("rr_busy", busy, 1);
    rst = 1; if_req = 0;
    tick; chk("rr_busy0", busy, 0); chk("rr_addr0", ma1, 0); chk("rr_rdata0", if_rdata, 0);
    chk("rr_ack0", if_ack, 0);
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      tick; chk("rr_no_ack", if_ack, 0);
    end
    if_req = 1;
    tick; tick;
    tick; chk("rr_new_ack", if_ack, 1); chk("rr_new_rdata", if_rdata, 16'hBEEF);
    if_req = 0;
    tick;
    d_we = 1; d_addr = 8'h30; d_wdata = 16'h5555; d_req = 1;
    tick; chk("rw_wr_en", wr1, 1);
    rst = 1; d_req = 0;
    tick; chk("rw_wr_en0", wr1, 0); chk("rw_ack0", d_ack, 0); chk("rw_grant0", grant_d, 0);
    rst = 0;
    tick; chk("rw_no_ack", d_ack, 0);
    d_we = 1; d_addr = 8'h40; d_wdata = 16'hA5A5; d_req = 1;
    tick; chk("bw_grant_d", grant_d, 1);
    if_addr = 8'h40; if_req = 1;
    tick; chk("bw_d_ack", d_ack, 1); chk("bw_if_wait", if_ack, 0);
    d_req = 0;
    tick; chk("bw_idle", busy, 0);
    tick; chk("bw_f_busy", busy, 1); chk("bw_f_owner", grant_d, 0); chk("bw_f_addr", ma1, 8'h40);
    tick; chk("bw_f_ack_lo", if_ack, 0);
    tick; chk("bw_f_ack", if_ack, 1); chk("bw_f_rdata", if_rdata, 16'hA5A5);
    if_req = 0;
    tick;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
